// File: rtl/core_dbus_bridge_if.sv
// Core data-port / system-bus bundle for core_dbus_bridge.
// The master modport is the bridge's view. The bridge is a slave to the core
// on the core_* side and a master on the bus_* side.
// The slave modport is the environment's view: the core plus the bus fabric.
interface core_dbus_bridge_if;
  // Core side
  logic        core_dvalid;
  logic [31:0] core_addr;
  logic        core_wen;
  logic [3:0]  core_be;
  logic [31:0] core_wdata;
  logic [31:0] core_rdata;
  logic        stall;
  // Bus side
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;
  // Abort indication
  logic        err;

  modport master (
    input  core_dvalid, core_addr, core_wen, core_be, core_wdata,
    output core_rdata, stall,
    output bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata,
    output err
  );

  modport slave (
    output core_dvalid, core_addr, core_wen, core_be, core_wdata,
    input  core_rdata, stall,
    input  bus_req, bus_addr, bus_we, bus_be, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata,
    input  err
  );
endinterface

// File: rtl/core_dbus_bridge.sv
// Single-outstanding bridge from a core load/store port to a req/gnt/rvalid bus.
//
// Handshake semantics:
//   Core side: when core_dvalid=1 in IDLE, the access is accepted on that edge.
//     stall stays high until the DONE cycle, and core_rdata is valid in DONE.
//   Bus side: bus_req stays high with stable fields until the bus_gnt edge.
//     After that, exactly one bus_rvalid completes the access. The rvalid may
//     share the gnt cycle.
//   A TIMEOUT-cycle budget, counted from REQ entry, aborts the access into DONE
//     with err=1 and zero data. A response in the last budget cycle still wins.
//   bus_rvalid outside REQ+gnt or WAIT is ignored.
// state_o exposes the FSM state for debug and checkers.
module core_dbus_bridge #(
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rstn,
  core_dbus_bridge_if.master dbus,
  output logic [1:0]         state_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // The counter is wide enough to hold TIMEOUT itself, so it can saturate there.
  localparam int              CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = (TIMEOUT < 1) ? '0 : CW'(TIMEOUT - 1);

  logic [1:0]    state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          got_resp;

  // Next-state, capture, response and timeout decisions
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wen_d    = wen_q;
    be_d     = be_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = 1'b0;
    cnt_d    = cnt_q;
    got_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (dbus.core_dvalid) begin
          addr_d  = dbus.core_addr;
          wen_d   = dbus.core_wen;
          be_d    = dbus.core_be;
          wdata_d = dbus.core_wdata;
          state_d = S_REQ;
        end
      end
      S_REQ, S_WAIT: begin
        // In REQ, a response only counts together with the grant.
        got_resp = (state_q == S_REQ) ? (dbus.bus_gnt && dbus.bus_rvalid)
                                      : dbus.bus_rvalid;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        if (got_resp) begin
          rdata_d = wen_q ? 32'h0 : dbus.bus_rdata;
          state_d = S_DONE;
        end else if (cnt_q >= CNT_LAST) begin
          // The last budgeted cycle passed without a response.
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (state_q == S_REQ && dbus.bus_gnt) begin
          state_d = S_WAIT;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and capture registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= 32'h0;
      wen_q   <= 1'b0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wen_q   <= wen_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus fields come straight from the capture registers, so they stay stable while requesting.
  assign dbus.bus_req    = (state_q == S_REQ);
  assign dbus.bus_addr   = addr_q & 32'hFFFF_FFFC;
  assign dbus.bus_we     = wen_q;
  assign dbus.bus_be     = be_q;
  assign dbus.bus_wdata  = wdata_q;
  assign dbus.core_rdata = rdata_q;
  assign dbus.err        = err_q;
  assign dbus.stall      = (state_q == S_IDLE) ? dbus.core_dvalid
                                               : ((state_q == S_REQ) || (state_q == S_WAIT));
  assign state_o         = state_q;

endmodule

// File: tb/tb_core_dbus_bridge.sv
// Bench for core_dbus_bridge.
// dut_a uses the default TIMEOUT. dut_b uses TIMEOUT=4 for the abort cases.
// sel_to selects which DUT receives the stimulus and which DUT is observed.
module tb_core_dbus_bridge;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  localparam int         TO_B    = 4;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sel_to = 1'b0;
  logic        dvalid = 1'b0;
  logic        c_wen = 1'b0;
  logic        gnt = 1'b0;
  logic        rvalid = 1'b0;
  logic [31:0] c_addr = 32'h0;
  logic [31:0] c_wdata = 32'h0;
  logic [31:0] b_rdata = 32'h0;
  logic [3:0]  c_be = 4'h0;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;

  logic [1:0]  st_a, st_b;

  core_dbus_bridge_if ifa ();
  core_dbus_bridge_if ifb ();

  core_dbus_bridge #(.TIMEOUT(255)) dut_a (
    .clk(clk), .rstn(rstn), .dbus(ifa), .state_o(st_a)
  );
  core_dbus_bridge #(.TIMEOUT(TO_B)) dut_b (
    .clk(clk), .rstn(rstn), .dbus(ifb), .state_o(st_b)
  );

  // Stimulus routing
  assign ifa.core_dvalid = dvalid & ~sel_to;
  assign ifb.core_dvalid = dvalid & sel_to;
  assign ifa.bus_gnt     = gnt & ~sel_to;
  assign ifb.bus_gnt     = gnt & sel_to;
  assign ifa.bus_rvalid  = rvalid & ~sel_to;
  assign ifb.bus_rvalid  = rvalid & sel_to;
  assign ifa.core_addr   = c_addr;
  assign ifb.core_addr   = c_addr;
  assign ifa.core_wen    = c_wen;
  assign ifb.core_wen    = c_wen;
  assign ifa.core_be     = c_be;
  assign ifb.core_be     = c_be;
  assign ifa.core_wdata  = c_wdata;
  assign ifb.core_wdata  = c_wdata;
  assign ifa.bus_rdata   = b_rdata;
  assign ifb.bus_rdata   = b_rdata;

  // Observation mux
  logic [31:0] o_rdata, o_addr, o_wdata;
  logic [3:0]  o_be;
  logic        o_stall, o_req, o_we, o_err;
  logic [1:0]  o_state;
  assign o_rdata = sel_to ? ifb.core_rdata : ifa.core_rdata;
  assign o_addr  = sel_to ? ifb.bus_addr   : ifa.bus_addr;
  assign o_wdata = sel_to ? ifb.bus_wdata  : ifa.bus_wdata;
  assign o_be    = sel_to ? ifb.bus_be     : ifa.bus_be;
  assign o_stall = sel_to ? ifb.stall      : ifa.stall;
  assign o_req   = sel_to ? ifb.bus_req    : ifa.bus_req;
  assign o_we    = sel_to ? ifb.bus_we     : ifa.bus_we;
  assign o_err   = sel_to ? ifb.err        : ifa.err;
  assign o_state = sel_to ? st_b           : st_a;

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every DONE cycle consumes one expected {err, rdata}
  always @(negedge clk) begin
    if (rstn && o_state == ST_DONE) begin
      if (exp_q.size() == 0) begin
        check_eq("done_unexpected", 64'(1), 64'(0));
      end else begin
        mon_exp = exp_q.pop_front();
        check_eq("done_rdata", 64'(o_rdata), 64'(mon_exp[31:0]));
        check_eq("done_err", 64'(o_err), 64'(mon_exp[32]));
      end
    end
  end

  // Idle cycles, with stray bus_rvalid that must be ignored
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      dvalid  = 1'b0;
      gnt     = 1'b0;
      rvalid  = 1'($urandom_range(0, 1));
      b_rdata = $urandom;
      @(negedge clk);
      check_eq("idle_state", 64'(o_state), 64'(ST_IDLE));
      check_eq("idle_stall", 64'(o_stall), 64'(0));
      check_eq("idle_req", 64'(o_req), 64'(0));
    end
  endtask

  // One access that completes with a response; ends at the DONE-cycle negedge
  task automatic do_access(input logic [31:0] addr, input logic wen, input logic [3:0] be,
                           input logic [31:0] wdata, input int gnt_d, input int rv_d,
                           input logic [31:0] rdata);
    logic [31:0] exp_addr;
    exp_addr = {addr[31:2], 2'b00};
    step();
    dvalid = 1'b1; c_addr = addr; c_wen = wen; c_be = be; c_wdata = wdata;
    gnt = 1'b0; rvalid = 1'b0;
    exp_q.push_back({1'b0, (wen ? 32'h0 : rdata)});
    @(negedge clk);
    check_eq("acc_idle_state", 64'(o_state), 64'(ST_IDLE));
    check_eq("acc_idle_stall", 64'(o_stall), 64'(1));
    check_eq("acc_idle_req", 64'(o_req), 64'(0));
    for (int i = 0; i <= gnt_d; i++) begin
      step();
      dvalid  = 1'b0;
      c_addr  = $urandom; c_wen = 1'($urandom_range(0, 1));
      c_be    = 4'($urandom_range(0, 15)); c_wdata = $urandom;
      gnt     = (i == gnt_d);
      rvalid  = (i == gnt_d) && (rv_d == 0);
      b_rdata = rvalid ? rdata : $urandom;
      @(negedge clk);
      check_eq("req_state", 64'(o_state), 64'(ST_REQ));
      check_eq("req_req", 64'(o_req), 64'(1));
      check_eq("req_addr", 64'(o_addr), 64'(exp_addr));
      check_eq("req_we", 64'(o_we), 64'(wen));
      check_eq("req_be", 64'(o_be), 64'(be));
      check_eq("req_wdata", 64'(o_wdata), 64'(wdata));
      check_eq("req_stall", 64'(o_stall), 64'(1));
    end
    for (int i = 1; i <= rv_d; i++) begin
      step();
      gnt     = 1'b0;
      rvalid  = (i == rv_d);
      b_rdata = rvalid ? rdata : $urandom;
      @(negedge clk);
      check_eq("wait_state", 64'(o_state), 64'(ST_WAIT));
      check_eq("wait_req", 64'(o_req), 64'(0));
      check_eq("wait_stall", 64'(o_stall), 64'(1));
    end
    step();
    gnt = 1'b0; rvalid = 1'b0; b_rdata = $urandom;
    dvalid = 1'($urandom_range(0, 1));
    @(negedge clk);
    check_eq("done_state", 64'(o_state), 64'(ST_DONE));
    check_eq("done_stall", 64'(o_stall), 64'(0));
    check_eq("done_req", 64'(o_req), 64'(0));
  endtask

  // Access without any response on dut_b; it must abort after TO_B cycles
  task automatic do_timeout(input logic [31:0] addr, input int gnt_d);
    step();
    dvalid = 1'b1; c_addr = addr; c_wen = 1'b0; c_be = 4'hF; c_wdata = 32'h0;
    gnt = 1'b0; rvalid = 1'b0;
    exp_q.push_back({1'b1, 32'h0});
    @(negedge clk);
    check_eq("to_idle_stall", 64'(o_stall), 64'(1));
    for (int i = 0; i < TO_B; i++) begin
      step();
      dvalid = 1'b0;
      gnt    = (i == gnt_d);
      @(negedge clk);
      check_eq("to_state", 64'(o_state), 64'((i <= gnt_d) ? ST_REQ : ST_WAIT));
      check_eq("to_stall", 64'(o_stall), 64'(1));
    end
    step();
    gnt = 1'b0;
    @(negedge clk);
    check_eq("to_done_state", 64'(o_state), 64'(ST_DONE));
    check_eq("to_done_stall", 64'(o_stall), 64'(0));
    step();
    rvalid = 1'b1; b_rdata = 32'h7777_7777;
    @(negedge clk);
    check_eq("to_after_state", 64'(o_state), 64'(ST_IDLE));
    check_eq("to_after_err", 64'(o_err), 64'(0));
    step();
    rvalid = 1'b0;
    @(negedge clk);
    check_eq("to_late_state", 64'(o_state), 64'(ST_IDLE));
    check_eq("to_late_rdata", 64'(o_rdata), 64'(0));
  endtask

  initial begin
    // Reset values, with stall following dvalid combinationally
    rstn = 1'b0; dvalid = 1'b1;
    c_addr = 32'hFFFF_FFFF; c_wen = 1'b1; c_be = 4'hF; c_wdata = 32'hFFFF_FFFF;
    repeat (2) step();
    @(negedge clk);
    check_eq("rst_state", 64'(o_state), 64'(ST_IDLE));
    check_eq("rst_req", 64'(o_req), 64'(0));
    check_eq("rst_addr", 64'(o_addr), 64'(0));
    check_eq("rst_we", 64'(o_we), 64'(0));
    check_eq("rst_be", 64'(o_be), 64'(0));
    check_eq("rst_wdata", 64'(o_wdata), 64'(0));
    check_eq("rst_rdata", 64'(o_rdata), 64'(0));
    check_eq("rst_err", 64'(o_err), 64'(0));
    check_eq("rst_stall_hi", 64'(o_stall), 64'(1));
    dvalid = 1'b0;
    #1;
    check_eq("rst_stall_lo", 64'(o_stall), 64'(0));
    rstn = 1'b1;
    idle(2);

    // Load 0x103, gnt in first REQ cycle, rvalid two cycles later
    do_access(32'h0000_0103, 1'b0, 4'hF, 32'h0, 0, 2, 32'hDEAD_BEEF);
    idle(1);
    // Store with grant delayed three cycles; the read data bus carries junk
    do_access(32'h0000_0204, 1'b1, 4'b0011, 32'h0000_ABCD, 3, 1, 32'h1234_5678);
    idle(1);
    // gnt+rvalid in the first REQ cycle: minimum latency
    do_access(32'h0000_0020, 1'b0, 4'hF, 32'h0, 0, 0, 32'h1122_3344);
    idle(1);
    // Back-to-back loads
    do_access(32'h0000_0010, 1'b0, 4'hF, 32'h0, 0, 1, 32'hA5A5_0010);
    do_access(32'h0000_0014, 1'b0, 4'hF, 32'h0, 1, 0, 32'h5A5A_0014);

    // Random mix of loads and stores
    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 1) == 1) idle(1);
      do_access($urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom);
    end
    idle(2);

    // Reset while in WAIT abandons the access
    step();
    dvalid = 1'b1; c_addr = 32'h0000_0200; c_wen = 1'b0; c_be = 4'hF; c_wdata = 32'h0;
    step();
    dvalid = 1'b0; gnt = 1'b1;
    @(negedge clk);
    check_eq("rw_req_state", 64'(o_state), 64'(ST_REQ));
    step();
    gnt = 1'b0;
    @(negedge clk);
    check_eq("rw_wait_state", 64'(o_state), 64'(ST_WAIT));
    step();
    rstn = 1'b0;
    step();
    @(negedge clk);
    check_eq("rw_rst_state", 64'(o_state), 64'(ST_IDLE));
    check_eq("rw_rst_req", 64'(o_req), 64'(0));
    check_eq("rw_rst_err", 64'(o_err), 64'(0));
    check_eq("rw_rst_stall", 64'(o_stall), 64'(0));
    rstn = 1'b1;
    step();
    rvalid = 1'b1; b_rdata = 32'h5555_AAAA;
    @(negedge clk);
    check_eq("rw_rv_state", 64'(o_state), 64'(ST_IDLE));
    step();
    rvalid = 1'b0;
    @(negedge clk);
    check_eq("rw_post_state", 64'(o_state), 64'(ST_IDLE));
    check_eq("rw_post_rdata", 64'(o_rdata), 64'(0));
    check_eq("rw_post_err", 64'(o_err), 64'(0));
    idle(1);

    // Short-timeout instance
    sel_to = 1'b1;
    idle(1);
    do_access(32'h0000_0040, 1'b0, 4'hF, 32'h0, 0, 0, 32'hCAFE_F00D);
    do_timeout(32'h0000_0044, 1);
    // Response in the last budgeted cycle beats the timeout
    do_access(32'h0000_0048, 1'b0, 4'hF, 32'h0, 0, TO_B - 1, 32'h0BAD_C0DE);
    idle(2);

    check_eq("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
